// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the run/halt sequencer: controller states,
// host command encodings, halt cause encodings and the halt opcode default.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } run_state_e;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_HOST     = 2'b01;
    localparam logic [1:0] CAUSE_OPCODE   = 2'b10;
    localparam logic [1:0] CAUSE_BP_LIMIT = 2'b11;

    localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

endpackage

// File: rtl/cpu_run_controller_halt_detect.sv
// Combinational halt detection for the RUN state. The host halt wins over
// the halt opcode, which wins over a breakpoint hit. The breakpoint is
// masked while skip_bp is set so a run can resume from a breakpointed PC.
module halt_detect
    import cpu_ctrl_pkg::*;
#(
    parameter int         PC_WIDTH    = 32,
    parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic                host_halt,
    input  logic [5:0]          opcode,
    input  logic [PC_WIDTH-1:0] program_counter,
    input  logic                bp_enable,
    input  logic [PC_WIDTH-1:0] bp_addr,
    input  logic                skip_bp,
    output logic                halt_req,
    output logic [1:0]          cause
);

    // Prioritised selection of the halt reason for this cycle.
    always_comb begin
        halt_req = 1'b0;
        cause    = CAUSE_NONE;
        if (host_halt) begin
            halt_req = 1'b1;
            cause    = CAUSE_HOST;
        end else if (opcode == HALT_OPCODE) begin
            halt_req = 1'b1;
            cause    = CAUSE_OPCODE;
        end else if (bp_enable && (program_counter == bp_addr) && !skip_bp) begin
            halt_req = 1'b1;
            cause    = CAUSE_BP_LIMIT;
        end else begin
            halt_req = 1'b0;
            cause    = CAUSE_NONE;
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/halt sequencer for the single-cycle core. cpu_enable gates every
// architectural update and is combinational so a halt stops the core in the
// very cycle it is detected. Status outputs are registered.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int         PC_WIDTH    = 32,
    parameter int         COUNT_WIDTH = 32,
    parameter int         LIMIT_WIDTH = 16,
    parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic                   bp_enable,
    input  logic [PC_WIDTH-1:0]    bp_addr,
    input  logic [LIMIT_WIDTH-1:0] cycle_limit,
    input  logic [PC_WIDTH-1:0]    program_counter,
    input  logic [31:0]            instruction,
    output logic                   cpu_enable,
    output logic                   running,
    output logic [1:0]             halt_cause,
    output logic                   limit_hit,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    run_state_e             state_r, state_next_s;
    logic [LIMIT_WIDTH-1:0] run_count_r;
    logic [LIMIT_WIDTH:0]   run_count_inc_s;
    logic                   skip_bp_r;
    logic                   running_r;
    logic [1:0]             halt_cause_r;
    logic                   limit_hit_r;
    logic [COUNT_WIDTH-1:0] retired_count_r;

    logic                   cmd_ready_s;
    logic                   cmd_accept_s;
    logic                   host_halt_s;
    logic                   halt_req_s;
    logic [1:0]             det_cause_s;
    logic                   limit_reached_s;
    logic                   cpu_enable_s;
    logic                   enter_run_s;
    logic                   exit_run_s;
    logic [1:0]             exit_cause_s;
    logic                   exit_limit_s;
    logic                   instr_unused_s;

    // Only the opcode field matters here; the rest of the word is ignored.
    assign instr_unused_s = ^instruction[25:0];

    assign cmd_ready_s  = (state_r != ST_STEP);
    assign cmd_accept_s = cmd_valid && cmd_ready_s;
    assign host_halt_s  = cmd_accept_s && (cmd_op == CMD_HALT);

    // One extra bit keeps a saturated counter from ever matching a limit.
    assign run_count_inc_s = {1'b0, run_count_r} + {{LIMIT_WIDTH{1'b0}}, 1'b1};
    assign limit_reached_s = (cycle_limit != {LIMIT_WIDTH{1'b0}}) &&
                             (run_count_inc_s == {1'b0, cycle_limit});

    halt_detect #(
        .PC_WIDTH    (PC_WIDTH),
        .HALT_OPCODE (HALT_OPCODE)
    ) u_halt_detect (
        .host_halt       (host_halt_s),
        .opcode          (instruction[31:26]),
        .program_counter (program_counter),
        .bp_enable       (bp_enable),
        .bp_addr         (bp_addr),
        .skip_bp         (skip_bp_r),
        .halt_req        (halt_req_s),
        .cause           (det_cause_s)
    );

    // Next-state, execute enable and run entry/exit events.
    always_comb begin
        state_next_s = state_r;
        cpu_enable_s = 1'b0;
        enter_run_s  = 1'b0;
        exit_run_s   = 1'b0;
        exit_cause_s = CAUSE_NONE;
        exit_limit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_accept_s && (cmd_op == CMD_RUN)) begin
                    state_next_s = ST_RUN;
                    enter_run_s  = 1'b1;
                end else if (cmd_accept_s && (cmd_op == CMD_STEP)) begin
                    state_next_s = ST_STEP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                cpu_enable_s = 1'b1;
                state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (halt_req_s) begin
                    state_next_s = ST_IDLE;
                    exit_run_s   = 1'b1;
                    exit_cause_s = det_cause_s;
                end else if (limit_reached_s) begin
                    cpu_enable_s = 1'b1;
                    state_next_s = ST_IDLE;
                    exit_run_s   = 1'b1;
                    exit_cause_s = CAUSE_BP_LIMIT;
                    exit_limit_s = 1'b1;
                end else begin
                    cpu_enable_s = 1'b1;
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered running flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            running_r <= (state_next_s != ST_IDLE);
        end
    end

    // Per-run executed-cycle counter (saturating) and breakpoint skip flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_count_r <= {LIMIT_WIDTH{1'b0}};
            skip_bp_r   <= 1'b0;
        end else if (enter_run_s) begin
            run_count_r <= {LIMIT_WIDTH{1'b0}};
            skip_bp_r   <= 1'b1;
        end else if (state_r == ST_RUN) begin
            skip_bp_r <= 1'b0;
            if (cpu_enable_s && (run_count_r != {LIMIT_WIDTH{1'b1}})) begin
                run_count_r <= run_count_inc_s[LIMIT_WIDTH-1:0];
            end
        end
    end

    // Halt cause: cleared on run entry, captured on run exit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halt_cause_r <= CAUSE_NONE;
            limit_hit_r  <= 1'b0;
        end else if (enter_run_s) begin
            halt_cause_r <= CAUSE_NONE;
            limit_hit_r  <= 1'b0;
        end else if (exit_run_s) begin
            halt_cause_r <= exit_cause_s;
            limit_hit_r  <= exit_limit_s;
        end
    end

    // Retired-instruction count, wraps naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_count_r <= {COUNT_WIDTH{1'b0}};
        end else if (cpu_enable_s) begin
            retired_count_r <= retired_count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign cmd_ready     = cmd_ready_s;
    assign cpu_enable    = cpu_enable_s;
    assign running       = running_r;
    assign halt_cause    = halt_cause_r;
    assign limit_hit     = limit_hit_r;
    assign retired_count = retired_count_r;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed vector table covering the main
// scenarios, a mid-run reset sequence, then random traffic against a model.
module tb_cpu_run_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        bp_enable;
    logic [31:0] bp_addr;
    logic [15:0] cycle_limit;
    logic [31:0] program_counter;
    logic [31:0] instruction;
    logic        cpu_enable;
    logic        running;
    logic [1:0]  halt_cause;
    logic        limit_hit;
    logic [31:0] retired_count;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [1:0]  NOP  = 2'b00;
    localparam logic [1:0]  RUN  = 2'b01;
    localparam logic [1:0]  STEP = 2'b10;
    localparam logic [1:0]  HALT = 2'b11;
    localparam logic [31:0] HI   = 32'hFC00_0000;

    cpu_run_controller dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .bp_enable       (bp_enable),
        .bp_addr         (bp_addr),
        .cycle_limit     (cycle_limit),
        .program_counter (program_counter),
        .instruction     (instruction),
        .cpu_enable      (cpu_enable),
        .running         (running),
        .halt_cause      (halt_cause),
        .limit_hit       (limit_hit),
        .retired_count   (retired_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic        bpe;
        logic [31:0] bpa;
        logic [15:0] lim;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        en;
        logic        rdy;
        logic        run;
        logic [1:0]  cause;
        logic        lh;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [1:0] op, input logic bpe,
                       input logic [31:0] bpa, input logic [15:0] lim,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic en, input logic rdy, input logic run,
                       input logic [1:0] cause, input logic lh, input logic [31:0] ret);
        vec_t t;
        t.v = v; t.op = op; t.bpe = bpe; t.bpa = bpa; t.lim = lim; t.pc = pc; t.ins = ins;
        t.en = en; t.rdy = rdy; t.run = run; t.cause = cause; t.lh = lh; t.ret = ret;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic bpe,
                         input logic [31:0] bpa, input logic [15:0] lim,
                         input logic [31:0] pc, input logic [31:0] ins);
        cmd_valid = v; cmd_op = op; bp_enable = bpe; bp_addr = bpa;
        cycle_limit = lim; program_counter = pc; instruction = ins;
    endtask

    // Reference model state, in terms of the controller's behavioural rules.
    int          m_mode;   // 0 halted, 1 free running, 2 single step pending
    bit          m_first;  // first cycle of a run: breakpoint ignored
    int          m_exec;   // instructions committed in the current run
    logic [1:0]  m_cause;
    logic        m_lh;
    logic [31:0] m_ret;

    initial begin
        logic        r_v, r_bpe, e_en, e_rdy, acc, h_host, h_opc, h_bp;
        logic [1:0]  r_op;
        logic [31:0] r_bpa, r_pc, r_ins;
        logic [15:0] r_lim;
        logic [5:0]  opc;

        // STEP x3
        add(1, STEP, 0, 0, 0, 32'h0, 0, 0, 1, 1, 0, 0, 0);
        add(0, NOP,  0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1);
        add(1, STEP, 0, 0, 0, 32'h4, 0, 0, 1, 1, 0, 0, 1);
        add(0, NOP,  0, 0, 0, 32'h4, 0, 1, 0, 0, 0, 0, 2);
        add(1, STEP, 0, 0, 0, 32'h8, 0, 0, 1, 1, 0, 0, 2);
        add(0, NOP,  0, 0, 0, 32'h8, 0, 1, 0, 0, 0, 0, 3);
        // RUN with cycle limit 5
        add(1, RUN,  0, 0, 5, 32'h100, 0, 0, 1, 1, 0, 0, 3);
        add(0, NOP,  0, 0, 5, 32'h100, 0, 1, 1, 1, 0, 0, 4);
        add(0, NOP,  0, 0, 5, 32'h104, 0, 1, 1, 1, 0, 0, 5);
        add(0, NOP,  0, 0, 5, 32'h108, 0, 1, 1, 1, 0, 0, 6);
        add(0, NOP,  0, 0, 5, 32'h10C, 0, 1, 1, 1, 0, 0, 7);
        add(0, NOP,  0, 0, 5, 32'h110, 0, 1, 1, 0, 3, 1, 8);
        // Breakpoint at 0x10, then resume through it, then host HALT
        add(1, RUN,  1, 32'h10, 0, 32'h08, 0, 0, 1, 1, 0, 0, 8);
        add(0, NOP,  1, 32'h10, 0, 32'h08, 0, 1, 1, 1, 0, 0, 9);
        add(0, NOP,  1, 32'h10, 0, 32'h0C, 0, 1, 1, 1, 0, 0, 10);
        add(0, NOP,  1, 32'h10, 0, 32'h10, 0, 0, 1, 0, 3, 0, 10);
        add(1, RUN,  1, 32'h10, 0, 32'h10, 0, 0, 1, 1, 0, 0, 10);
        add(0, NOP,  1, 32'h10, 0, 32'h10, 0, 1, 1, 1, 0, 0, 11);
        add(0, NOP,  1, 32'h10, 0, 32'h14, 0, 1, 1, 1, 0, 0, 12);
        add(1, HALT, 1, 32'h10, 0, 32'h18, 0, 0, 1, 0, 1, 0, 12);
        // Halt opcode at 0x0C, then STEP commits it
        add(1, RUN,  0, 0, 0, 32'h04, 0,  0, 1, 1, 0, 0, 12);
        add(0, NOP,  0, 0, 0, 32'h04, 0,  1, 1, 1, 0, 0, 13);
        add(0, NOP,  0, 0, 0, 32'h08, 0,  1, 1, 1, 0, 0, 14);
        add(0, NOP,  0, 0, 0, 32'h0C, HI, 0, 1, 0, 2, 0, 14);
        add(1, STEP, 0, 0, 0, 32'h0C, HI, 0, 1, 1, 2, 0, 14);
        add(0, NOP,  0, 0, 0, 32'h0C, HI, 1, 0, 0, 2, 0, 15);
        // Host HALT beats halt opcode and breakpoint in the same cycle
        add(1, RUN,  1, 32'h20, 0, 32'h1C, 0,  0, 1, 1, 0, 0, 15);
        add(0, NOP,  1, 32'h20, 0, 32'h1C, 0,  1, 1, 1, 0, 0, 16);
        add(1, HALT, 1, 32'h20, 0, 32'h20, HI, 0, 1, 0, 1, 0, 16);
        // Halt opcode beats breakpoint
        add(1, RUN,  1, 32'h34, 0, 32'h30, 0,  0, 1, 1, 0, 0, 16);
        add(0, NOP,  1, 32'h34, 0, 32'h30, 0,  1, 1, 1, 0, 0, 17);
        add(0, NOP,  1, 32'h34, 0, 32'h34, HI, 0, 1, 0, 2, 0, 17);
        // STEP ignores breakpoint, opcode, and a HALT offered while busy
        add(1, STEP, 1, 32'h40, 0, 32'h40, 0,  0, 1, 1, 2, 0, 17);
        add(1, HALT, 1, 32'h40, 0, 32'h40, HI, 1, 0, 0, 2, 0, 18);
        // Limit of 1 gives exactly one commit
        add(1, RUN,  0, 0, 1, 32'h0, 0, 0, 1, 1, 0, 0, 18);
        add(0, NOP,  0, 0, 1, 32'h0, 0, 1, 1, 0, 3, 1, 19);

        // Reset values
        drive(0, NOP, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset cpu_enable", cpu_enable, 0);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset running", running, 0);
        chk("reset halt_cause", halt_cause, 0);
        chk("reset limit_hit", limit_hit, 0);
        chk("reset retired_count", retired_count, 0);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].bpe, vecs[i].bpa,
                  vecs[i].lim, vecs[i].pc, vecs[i].ins);
            #1;
            chk($sformatf("vec%0d cpu_enable", i), cpu_enable, vecs[i].en);
            chk($sformatf("vec%0d cmd_ready", i), cmd_ready, vecs[i].rdy);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d running", i), running, vecs[i].run);
            chk($sformatf("vec%0d halt_cause", i), halt_cause, vecs[i].cause);
            chk($sformatf("vec%0d limit_hit", i), limit_hit, vecs[i].lh);
            chk($sformatf("vec%0d retired_count", i), retired_count, vecs[i].ret);
        end

        // Reset asserted in the middle of a RUN cycle
        drive(1, RUN, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        drive(0, NOP, 0, 0, 0, 32'h4, 0);
        @(posedge clock);
        #1;
        chk("midrst retired before", retired_count, 20);
        drive(0, NOP, 0, 0, 0, 32'h8, 0);
        #1;
        chk("midrst cpu_enable before", cpu_enable, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst cpu_enable", cpu_enable, 0);
        chk("midrst running", running, 0);
        chk("midrst retired_count", retired_count, 0);
        chk("midrst halt_cause", halt_cause, 0);
        chk("midrst cmd_ready", cmd_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Random traffic against the model
        m_mode = 0; m_first = 0; m_exec = 0; m_cause = 2'b00; m_lh = 1'b0; m_ret = 32'd0;
        r_lim = 16'd0; r_bpe = 1'b0; r_bpa = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            r_v  = ($urandom_range(3) == 0);
            r_op = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) r_lim = ($urandom_range(2) == 0) ? 16'd0 : 16'($urandom_range(1, 10));
            if ($urandom_range(15) == 0) r_bpe = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) r_bpa = 32'(4 * $urandom_range(15));
            r_pc = 32'(4 * $urandom_range(15));
            opc  = ($urandom_range(15) == 0) ? 6'h3F : 6'($urandom_range(62));
            r_ins = {opc, 26'($urandom)};
            drive(r_v, r_op, r_bpe, r_bpa, r_lim, r_pc, r_ins);

            e_rdy  = (m_mode != 2);
            acc    = r_v && e_rdy;
            h_host = acc && (r_op == HALT);
            h_opc  = (r_ins[31:26] == 6'h3F);
            h_bp   = r_bpe && (r_pc == r_bpa) && !m_first;
            e_en   = (m_mode == 2) || ((m_mode == 1) && !(h_host || h_opc || h_bp));
            #1;
            chk($sformatf("rnd%0d cpu_enable", c), cpu_enable, e_en);
            chk($sformatf("rnd%0d cmd_ready", c), cmd_ready, e_rdy);

            if (e_en) m_ret = m_ret + 32'd1;
            if (m_mode == 0) begin
                if (acc && r_op == RUN) begin
                    m_mode = 1; m_first = 1; m_exec = 0; m_cause = 2'b00; m_lh = 1'b0;
                end else if (acc && r_op == STEP) begin
                    m_mode = 2;
                end
            end else if (m_mode == 2) begin
                m_mode = 0;
            end else begin
                m_first = 0;
                if (h_host) begin
                    m_mode = 0; m_cause = 2'b01; m_lh = 1'b0;
                end else if (h_opc) begin
                    m_mode = 0; m_cause = 2'b10; m_lh = 1'b0;
                end else if (h_bp) begin
                    m_mode = 0; m_cause = 2'b11; m_lh = 1'b0;
                end else begin
                    m_exec++;
                    if (r_lim != 16'd0 && m_exec == int'(r_lim)) begin
                        m_mode = 0; m_cause = 2'b11; m_lh = 1'b1;
                    end
                end
            end

            @(posedge clock);
            #1;
            chk($sformatf("rnd%0d running", c), running, (m_mode != 0));
            chk($sformatf("rnd%0d halt_cause", c), halt_cause, m_cause);
            chk($sformatf("rnd%0d limit_hit", c), limit_hit, m_lh);
            chk($sformatf("rnd%0d retired_count", c), retired_count, m_ret);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
